// File: rtl/ysyx_25040129_idu_scoreboard_pkg.sv
// Shared widths, compressed CSR index map and counter helpers for the IDU scoreboard.
package ysyx_25040129_idu_scoreboard_pkg;

  localparam int ysyx_25040129_REGS_DIG = 5;
  localparam int ysyx_25040129_CSR_DIG  = 4;

  // Internal compressed CSR indices; the decoder maps 12-bit CSR numbers onto these.
  typedef enum logic [ysyx_25040129_CSR_DIG-1:0] {
    CSR_MSTATUS  = 4'd0,
    CSR_MTVEC    = 4'd1,
    CSR_MEPC     = 4'd2,
    CSR_MCAUSE   = 4'd3,
    CSR_SATP     = 4'd4,
    CSR_MSCRATCH = 4'd5,
    CSR_MIE      = 4'd6,
    CSR_MIP      = 4'd7
  } csr_idx_e;

  localparam int CNT_W_DEF = 2;

  // Largest number of in-flight writers a counter of width w can track.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/ysyx_25040129_fwd_sel.sv
// Priority match of one source register against the forwarding stages (index 0 = youngest).
module ysyx_25040129_fwd_sel #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic [NUM_FWD-1:0]        fwd_wen,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      hit,
  output logic                      ok,
  output logic [XLEN-1:0]           data
);

  // Scan oldest to youngest so the youngest matching stage overwrites and wins.
  always_comb begin
    hit  = 1'b0;
    ok   = 1'b0;
    data = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_wen[i] && (fwd_rd[i*REG_AW +: REG_AW] == rs)) begin
        hit  = 1'b1;
        ok   = fwd_data_ok[i];
        data = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/ysyx_25040129_idu_scoreboard.sv
// Decode-stage scoreboard: per-register in-flight write counters, operand forwarding,
// and the IDU->EXU pipeline register.
module ysyx_25040129_idu_scoreboard
  import ysyx_25040129_idu_scoreboard_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = ysyx_25040129_REGS_DIG,
  parameter int CSR_AW  = ysyx_25040129_CSR_DIG,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_AW-1:0]         in_rs1,
  input  logic [REG_AW-1:0]         in_rs2,
  input  logic                      in_rs1_used,
  input  logic                      in_rs2_used,
  input  logic [XLEN-1:0]           in_rs1_data,
  input  logic [XLEN-1:0]           in_rs2_data,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic                      in_rd_wen,
  input  logic [CSR_AW-1:0]         in_csr_raddr,
  input  logic                      in_csr_read,
  input  logic [CSR_AW-1:0]         in_csr_waddr,
  input  logic                      in_csr_wen,
  input  logic [NUM_FWD-1:0]        fwd_wen,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic                      wb_valid,
  input  logic                      wb_rd_wen,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_csr_wen,
  input  logic [CSR_AW-1:0]         wb_csr_addr,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_rs1_val,
  output logic [XLEN-1:0]           out_rs2_val,
  output logic [REG_AW-1:0]         out_rd,
  output logic                      out_rd_wen,
  output logic [CSR_AW-1:0]         out_csr_waddr,
  output logic                      out_csr_wen,
  output logic [31:0]               stall_cnt
);

  localparam int NGPR = 1 << REG_AW;
  localparam int NCSR = 1 << CSR_AW;
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));

  logic [NGPR-1:0][CNT_W-1:0] gcnt;
  logic [NCSR-1:0][CNT_W-1:0] ccnt;

  logic            hit1, ok1, hit2, ok2;
  logic [XLEN-1:0] fdata1, fdata2;

  ysyx_25040129_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .rs(in_rs1), .fwd_wen(fwd_wen), .fwd_rd(fwd_rd), .fwd_data_ok(fwd_data_ok),
    .fwd_data(fwd_data), .hit(hit1), .ok(ok1), .data(fdata1)
  );

  ysyx_25040129_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .rs(in_rs2), .fwd_wen(fwd_wen), .fwd_rd(fwd_rd), .fwd_data_ok(fwd_data_ok),
    .fwd_data(fwd_data), .hit(hit2), .ok(ok2), .data(fdata2)
  );

  // A source only depends on the bypass network when a writer to it is in flight.
  logic            rs1_haz, rs2_haz, rs1_stall, rs2_stall, csr_stall, hazard, sat, fire;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign rs1_haz   = in_rs1_used && (in_rs1 != '0) && (gcnt[in_rs1] != '0);
  assign rs2_haz   = in_rs2_used && (in_rs2 != '0) && (gcnt[in_rs2] != '0);
  assign rs1_stall = rs1_haz && !(hit1 && ok1);
  assign rs2_stall = rs2_haz && !(hit2 && ok2);
  assign rs1_val   = rs1_haz ? fdata1 : in_rs1_data;
  assign rs2_val   = rs2_haz ? fdata2 : in_rs2_data;
  assign csr_stall = in_csr_read && (ccnt[in_csr_raddr] != '0);
  assign hazard    = rs1_stall || rs2_stall || csr_stall;

  // A full counter cannot take another writer without losing track of it.
  assign sat = (in_rd_wen && (in_rd != '0) && (gcnt[in_rd] == CMAX)) ||
               (in_csr_wen && (ccnt[in_csr_waddr] == CMAX));

  assign in_ready = (!out_valid || out_ready) && !hazard && !sat && !flush;
  assign fire     = in_valid && in_ready;

  // One-hot increment/decrement requests; x0 never participates.
  logic [NGPR-1:0] g_inc, g_dec;
  logic [NCSR-1:0] c_inc, c_dec;

  assign g_inc = (fire && in_rd_wen && (in_rd != '0)) ? (NGPR'(1) << in_rd) : '0;
  assign g_dec = (wb_valid && wb_rd_wen && (wb_rd != '0)) ? (NGPR'(1) << wb_rd) : '0;
  assign c_inc = (fire && in_csr_wen) ? (NCSR'(1) << in_csr_waddr) : '0;
  assign c_dec = (wb_valid && wb_csr_wen) ? (NCSR'(1) << wb_csr_addr) : '0;

  // In-flight counters: issue adds, retire subtracts, both together cancel, flush clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= '0;
      ccnt <= '0;
    end else if (flush) begin
      gcnt <= '0;
      ccnt <= '0;
    end else begin
      for (int r = 1; r < NGPR; r++) begin
        if (g_inc[r] && !g_dec[r])
          gcnt[r] <= gcnt[r] + CNT_W'(1);
        else if (g_dec[r] && !g_inc[r] && (gcnt[r] != '0))
          gcnt[r] <= gcnt[r] - CNT_W'(1);
      end
      for (int r = 0; r < NCSR; r++) begin
        if (c_inc[r] && !c_dec[r])
          ccnt[r] <= ccnt[r] + CNT_W'(1);
        else if (c_dec[r] && !c_inc[r] && (ccnt[r] != '0))
          ccnt[r] <= ccnt[r] - CNT_W'(1);
      end
    end
  end

  // Single-entry IDU->EXU register; loading on fire keeps full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_rs1_val   <= '0;
      out_rs2_val   <= '0;
      out_rd        <= '0;
      out_rd_wen    <= 1'b0;
      out_csr_waddr <= '0;
      out_csr_wen   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid     <= 1'b1;
      out_rs1_val   <= rs1_val;
      out_rs2_val   <= rs2_val;
      out_rd        <= in_rd;
      out_rd_wen    <= in_rd_wen;
      out_csr_waddr <= in_csr_waddr;
      out_csr_wen   <= in_csr_wen;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Counts cycles a presented instruction is held back by a dependency or a full counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (!flush && in_valid && !in_ready && (hazard || sat))
      stall_cnt <= stall_cnt + 32'd1;
  end

  // Retiring a writer that was never counted means WBU and IDU disagree.
  gpr_retire_tracked: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_valid && !flush && wb_rd_wen && (wb_rd != '0) && (gcnt[wb_rd] == '0)));

  csr_retire_tracked: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_valid && !flush && wb_csr_wen && (ccnt[wb_csr_addr] == '0)));

endmodule

// File: doc/ysyx_25040129_idu_scoreboard.md
Name: ysyx_25040129_idu_scoreboard

Overview:
- Parametrised successor to the decode-stage hazard/forwarding logic.
- Replaces fixed 3-stage rd comparison with a per-register in-flight write counter (GPR and CSR) and an N-source youngest-first forwarding network.
- Registers resolved operands into an IDU→EXU pipeline register with a valid/ready handshake.
- Sits between the decoder and EXU; retire updates come from WBU.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, GPR index width (4 for RV32E).
- CSR_AW, 4, internal compressed CSR index width.
- NUM_FWD, 3, forwarding sources; index 0 = youngest (EXU), then LSU, WBU.
- CNT_W, 2, per-register in-flight counter width; max in-flight writers = 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid / in_ready  in / out  1 / 1  decode handshake.
- in_rs1, in_rs2  in  REG_AW each  source indices.
- in_rs1_used, in_rs2_used  in  1 each  source actually read.
- in_rs1_data, in_rs2_data  in  XLEN each  regfile read data.
- in_rd  in  REG_AW; in_rd_wen  in  1  destination and write enable.
- in_csr_raddr  in  CSR_AW; in_csr_read  in  1  CSR read.
- in_csr_waddr  in  CSR_AW; in_csr_wen  in  1  CSR write.
- fwd_wen  in  NUM_FWD  stage holds a GPR writer.
- fwd_rd  in  NUM_FWD*REG_AW  stage destinations.
- fwd_data_ok  in  NUM_FWD  stage result available.
- fwd_data  in  NUM_FWD*XLEN  stage results.
- wb_valid  in  1  instruction retires this cycle.
- wb_rd_wen  in  1; wb_rd  in  REG_AW  retiring GPR write.
- wb_csr_wen  in  1; wb_csr_addr  in  CSR_AW  retiring CSR write.
- flush  in  1  kill all in-flight work younger than the retiring instruction.
- out_valid / out_ready  out / in  1 / 1  EXU handshake.
- out_rs1_val, out_rs2_val  out  XLEN each  resolved operands.
- out_rd  out  REG_AW; out_rd_wen  out  1.
- out_csr_waddr  out  CSR_AW; out_csr_wen  out  1.
- stall_cnt  out  32  hazard stall-cycle perf counter.

Behaviour:
- Reset: all GPR/CSR counters 0, out_valid 0, all out_* data 0, stall_cnt 0.
- Source hazard, rsX: rsX_used && rsX!=0 && gcnt[rsX]!=0.
  - Search fwd i=0..NUM_FWD-1; the first i with fwd_wen[i] && fwd_rd[i]==rsX wins.
  - Winner has fwd_data_ok: forward fwd_data[i], no stall.
  - Winner lacks fwd_data_ok, or no winner found: stall.
  - No hazard: regfile data is used.
- CSR hazard: in_csr_read && ccnt[in_csr_raddr]!=0 causes a stall. There is no CSR forwarding.
- Saturation stall: in_rd_wen && in_rd!=0 && gcnt[in_rd]==max, or in_csr_wen && ccnt[in_csr_waddr]==max.
- in_ready = (!out_valid || out_ready) && !hazard && !sat. Combinational, with no dependence on in_valid.
- Fire = in_valid && in_ready.
  - Next edge: output register loads, out_valid=1.
  - gcnt[in_rd]++ if in_rd_wen && in_rd!=0; ccnt[in_csr_waddr]++ if in_csr_wen.
- out_valid && out_ready && !fire: out_valid drops to 0.
- Retire (wb_valid): gcnt[wb_rd]-- if wb_rd_wen && wb_rd!=0; ccnt[wb_csr_addr]-- if wb_csr_wen.
- Same-register increment and decrement in one cycle: net unchanged.
- Decrement at 0 is a protocol error: simulation assertion fires, counter stays 0.
- x0 is never counted and never stalls.
- flush: counters cleared and out_valid=0 on the next edge. Fire, retire and the stall_cnt increment are ignored that cycle; in_ready is forced to 0 while flush is high.
- stall_cnt increments when in_valid && !in_ready && (hazard || sat). It wraps at 2^32.
- Latency: one cycle from fire to out_valid. A single-entry register gives full throughput with back-to-back fire while out_ready=1.
- Asynchronous reset mid-operation: state returns to reset values immediately, with no pending handshake honoured.

Decomposition:
- Shared package/defines holds:
  - ysyx_25040129_REGS_DIG and ysyx_25040129_CSR_DIG widths;
  - CSR index encodings (MSTATUS, MTVEC, MEPC, MCAUSE, SATP, MSCRATCH, …);
  - counter max constant.
- One natural sub-module, ysyx_25040129_fwd_sel: purely combinational priority match per source, instantiated twice (rs1, rs2), returning hit, ok and data.

Test Plan:
- Forward from EXU: issue add x5 (rd_wen), then read x5 with fwd_wen=001, fwd_rd[0]=5, fwd_data_ok[0]=1, fwd_data[0]=0x1234 -> in_ready=1, out_rs1_val=0x1234, no stall.
- Load-use stall: fwd_wen[0]=1, fwd_rd[0]=7, fwd_data_ok[0]=0; rs2=7 used -> in_ready=0 and stall_cnt+1 per cycle. Set fwd_data_ok[0]=1, data 0xCAFE -> fire, out_rs2_val=0xCAFE.
- Youngest priority: fwd stages 0 and 2 both write x3 with 0xAAAA and 0xBBBB -> out_rs1_val=0xAAAA.
- Saturation with CNT_W=2: issue three writers to x9 with no retire; the fourth writer to x9 -> in_ready=0. wb retire x9 -> in_ready=1 on the next cycle.
- CSR hazard: csrw MEPC in flight (ccnt=1); csrr MEPC -> stall until wb_csr_wen for MEPC, then fire. The same-cycle issue of another MEPC write plus retire keeps ccnt=1.
- Flush and x0: issue with rd=x0 -> counters unchanged. Issue writers to x1 and x2, then flush -> all counters 0, out_valid=0, and a subsequent read of x1 fires with regfile data. rst_n low mid-stall -> out_valid=0 and stall_cnt=0 immediately.
